// File: rtl/inertial_intf.sv
// -----------------------------------------------------------------------------
// inertial_intf
//   Sensor-side front end of the balance path. After a power-up wait it
//   programs the 6-axis IMU through the SPI monarch, then services every
//   data-ready interrupt with four byte reads (pitch rate low/high, vertical
//   acceleration low/high). A complete sample is presented to the inertial
//   integrator with a one-cycle vld strobe.
//
// Ports
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   INT      : IMU data-ready interrupt (asynchronous level, active-high)
//   done     : SPI monarch transaction complete (one-cycle pulse)
//   rd_data  : SPI monarch read data, low byte valid with done
//   wrt      : start SPI transaction (one-cycle pulse)
//   cmd      : SPI command word {addr,data}, held from wrt until done
//   vld      : new ptch_rt/AZ sample (one-cycle pulse)
//   ptch_rt  : signed pitch rate {high byte, low byte}
//   AZ       : signed vertical acceleration {high byte, low byte}
// -----------------------------------------------------------------------------
module inertial_intf #(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  typedef enum logic [3:0] {
    PWR_WAIT = 4'd0,
    INIT1    = 4'd1,
    INIT2    = 4'd2,
    INIT3    = 4'd3,
    INIT4    = 4'd4,
    WAIT_INT = 4'd5,
    RD_PL    = 4'd6,
    RD_PH    = 4'd7,
    RD_AL    = 4'd8,
    RD_AH    = 4'd9
  } state_t;

  // Command word issued on entry to each transaction state.
  function automatic logic [15:0] cmd_of(input state_t s);
    logic [15:0] c;
    case (s)
      INIT1:   c = 16'h0D02;  // enable data-ready INT
      INIT2:   c = 16'h1053;  // accel 208 Hz, +/-2 g
      INIT3:   c = 16'h1150;  // gyro 208 Hz, 250 dps
      INIT4:   c = 16'h1460;  // rounding on
      RD_PL:   c = 16'hA200;
      RD_PH:   c = 16'hA300;
      RD_AL:   c = 16'hAC00;
      RD_AH:   c = 16'hAD00;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [INIT_W-1:0] cnt_r;
  logic              int_meta_r;
  logic              int_sync_r;
  logic [7:0]        pl_r;
  logic [7:0]        ph_r;
  logic [7:0]        al_r;
  logic              done_ok_s;
  logic              wrt_nxt_s;
  logic [15:0]       cmd_nxt_s;
  logic              vld_nxt_s;
  logic              unused_s;

  // Only the low byte of the read data carries register contents.
  assign unused_s = ^rd_data[15:8];

  // A done coincident with wrt cannot belong to the new transaction.
  assign done_ok_s = done & ~wrt;

  // Two-flop synchronizer for the asynchronous interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta_r <= 1'b0;
      int_sync_r <= 1'b0;
    end else begin
      int_meta_r <= INT;
      int_sync_r <= int_meta_r;
    end
  end

  // Power-up wait counter, running only while waiting for the IMU to boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {INIT_W{1'b0}};
    end else if (state_r == PWR_WAIT) begin
      cnt_r <= cnt_r + {{(INIT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= PWR_WAIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus next values of the registered outputs.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      PWR_WAIT: if (&cnt_r)     next_state_s = INIT1;    else next_state_s = state_r;
      INIT1:    if (done_ok_s)  next_state_s = INIT2;    else next_state_s = state_r;
      INIT2:    if (done_ok_s)  next_state_s = INIT3;    else next_state_s = state_r;
      INIT3:    if (done_ok_s)  next_state_s = INIT4;    else next_state_s = state_r;
      INIT4:    if (done_ok_s)  next_state_s = WAIT_INT; else next_state_s = state_r;
      WAIT_INT: if (int_sync_r) next_state_s = RD_PL;    else next_state_s = state_r;
      RD_PL:    if (done_ok_s)  next_state_s = RD_PH;    else next_state_s = state_r;
      RD_PH:    if (done_ok_s)  next_state_s = RD_AL;    else next_state_s = state_r;
      RD_AL:    if (done_ok_s)  next_state_s = RD_AH;    else next_state_s = state_r;
      RD_AH:    if (done_ok_s)  next_state_s = WAIT_INT; else next_state_s = state_r;
      default:  next_state_s = PWR_WAIT;
    endcase

    // wrt fires on the edge that enters a transaction state, so it is
    // visible during the first cycle of that state.
    wrt_nxt_s = (next_state_s != state_r) &&
                (next_state_s != WAIT_INT) &&
                (next_state_s != PWR_WAIT);
    if (wrt_nxt_s) begin
      cmd_nxt_s = cmd_of(next_state_s);
    end else begin
      cmd_nxt_s = cmd;
    end
    vld_nxt_s = (state_r == RD_AH) && done_ok_s;
  end

  // Byte holding registers for the first three reads of a burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_r <= 8'h00;
      ph_r <= 8'h00;
      al_r <= 8'h00;
    end else begin
      if ((state_r == RD_PL) && done_ok_s) pl_r <= rd_data[7:0]; else pl_r <= pl_r;
      if ((state_r == RD_PH) && done_ok_s) ph_r <= rd_data[7:0]; else ph_r <= ph_r;
      if ((state_r == RD_AL) && done_ok_s) al_r <= rd_data[7:0]; else al_r <= al_r;
    end
  end

  // Registered SPI handshake and sample outputs. The AZ high byte is taken
  // straight from the final read so both words update on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      vld     <= 1'b0;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
    end else begin
      wrt <= wrt_nxt_s;
      cmd <= cmd_nxt_s;
      vld <= vld_nxt_s;
      if (vld_nxt_s) begin
        ptch_rt <= {ph_r, pl_r};
        AZ      <= {rd_data[7:0], al_r};
      end else begin
        ptch_rt <= ptch_rt;
        AZ      <= AZ;
      end
    end
  end

endmodule
